// File: rtl/mem_ctrl.sv
// mem_ctrl
// Shares one byte-wide RAM port between instruction fetch (IF) and
// load/store (MEM). Each granted access is split into 1, 2 or 4 byte beats
// on consecutive addresses. Bytes are little-endian, and address arithmetic
// wraps modulo 2^ADDR_W.
//
// Ports
//   clk_in, rst_in        clock and synchronous active-high reset
//   if_req_i/if_addr_i    IF word-read request (level) and fetch address
//   if_data_o/if_done_o   fetched word and its one-cycle completion pulse
//   mem_req_i/mem_we_i    MEM request (level) and store/load select
//   mem_len_i             00 byte, 01 half, 10/11 word
//   mem_addr_i            MEM base address
//   mem_wdata_i           store data, low byte first
//   mem_rdata_o           zero-extended load data
//   mem_done_o            one-cycle completion pulse
//   ram_din_i             RAM read byte, valid one cycle after the address
//   ram_dout_o/ram_a_o    registered RAM write byte and address
//   ram_wr_o              registered RAM write strobe
//   if_stall_req_o        IF stall request to the stall bus
//   mem_stall_req_o       MEM stall request to the stall bus
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; grant MEM first, then IF
// READ  | issue one address per cycle and capture bytes one cycle later
// WRITE | drive one address/byte pair per cycle with the strobe high
// DONE  | owner's done pulse is high; return to IDLE next cycle
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic              if_stall_req_o,
  output logic              mem_stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic              owner_mem_q;   // 1 = MEM owns the access, 0 = IF
  logic [2:0]        cnt_q;         // beat index of the address on ram_a_o
  logic [2:0]        n_q;           // beats in this access
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;        // bytes captured so far, upper bytes 0
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [2:0]        n_mem;
  logic [1:0]        rd_idx;
  logic [1:0]        wr_idx;
  logic [31:0]       rd_word_d;
  logic [7:0]        wr_byte_d;

  always_comb begin
    n_mem = 3'd4;
    case (mem_len_i)
      2'b00:   n_mem = 3'd1;
      2'b01:   n_mem = 3'd2;
      default: n_mem = 3'd4;
    endcase
  end

  // The byte on ram_din_i belongs to the beat issued one cycle earlier.
  assign rd_idx = cnt_q[1:0] - 2'd1;

  always_comb begin
    rd_word_d = rbuf_q;
    case (rd_idx)
      2'd0: rd_word_d[7:0]   = ram_din_i;
      2'd1: rd_word_d[15:8]  = ram_din_i;
      2'd2: rd_word_d[23:16] = ram_din_i;
      2'd3: rd_word_d[31:24] = ram_din_i;
      default: rd_word_d = rbuf_q;
    endcase
  end

  // Byte for the next write beat. Byte 0 is loaded directly at grant.
  assign wr_idx = cnt_q[1:0] + 2'd1;

  always_comb begin
    wr_byte_d = wdata_q[7:0];
    case (wr_idx)
      2'd0: wr_byte_d = wdata_q[7:0];
      2'd1: wr_byte_d = wdata_q[15:8];
      2'd2: wr_byte_d = wdata_q[23:16];
      2'd3: wr_byte_d = wdata_q[31:24];
      default: wr_byte_d = wdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q  <= 3'd0;
          rbuf_q <= 32'd0;
          if (mem_req_i) begin
            owner_mem_q <= 1'b1;
            ram_a_q     <= mem_addr_i;
            n_q         <= n_mem;
            wdata_q     <= mem_wdata_i;
            if (mem_we_i) begin
              ram_wr_q   <= 1'b1;
              ram_dout_q <= mem_wdata_i[7:0];
              state_q    <= S_WRITE;
            end else begin
              state_q <= S_READ;
            end
          end else if (if_req_i) begin
            owner_mem_q <= 1'b0;
            ram_a_q     <= if_addr_i;
            n_q         <= 3'd4;
            wdata_q     <= 32'd0;
            state_q     <= S_READ;
          end
        end

        S_READ: begin
          if (cnt_q != 3'd0) begin
            rbuf_q <= rd_word_d;
          end
          if (cnt_q == n_q) begin
            // Last byte is on ram_din_i now; publish the merged word.
            if (owner_mem_q) begin
              mem_rdata_q <= rd_word_d;
              mem_done_q  <= 1'b1;
            end else begin
              if_data_q <= rd_word_d;
              if_done_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            // Hold the final address while the last byte returns.
            if (cnt_q + 3'd1 < n_q) begin
              ram_a_q <= ram_a_q + ADDR_W'(1);
            end
          end
        end

        S_WRITE: begin
          if (cnt_q == n_q - 3'd1) begin
            ram_wr_q <= 1'b0;
            if (owner_mem_q) begin
              mem_done_q <= 1'b1;
            end else begin
              if_done_q <= 1'b1;
            end
            state_q <= S_DONE;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_a_q    <= ram_a_q + ADDR_W'(1);
            ram_dout_q <= wr_byte_d;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          ram_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_data_o   = if_data_q;
  assign if_done_o   = if_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_done_o  = mem_done_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_a_o     = ram_a_q;
  assign ram_wr_o    = ram_wr_q;

  assign if_stall_req_o  = if_req_i & ~if_done_q;
  assign mem_stall_req_o = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_done_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic        if_stall_req_o;
  logic        mem_stall_req_o;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .if_req_i        (if_req_i),
    .if_addr_i       (if_addr_i),
    .if_data_o       (if_data_o),
    .if_done_o       (if_done_o),
    .mem_req_i       (mem_req_i),
    .mem_we_i        (mem_we_i),
    .mem_len_i       (mem_len_i),
    .mem_addr_i      (mem_addr_i),
    .mem_wdata_i     (mem_wdata_i),
    .mem_rdata_o     (mem_rdata_o),
    .mem_done_o      (mem_done_o),
    .ram_din_i       (ram_din_i),
    .ram_dout_o      (ram_dout_o),
    .ram_a_o         (ram_a_o),
    .ram_wr_o        (ram_wr_o),
    .if_stall_req_o  (if_stall_req_o),
    .mem_stall_req_o (mem_stall_req_o)
  );

  // Byte RAM model (64 KiB, low address bits) with a preload port.
  logic [7:0]  ram [0:65535];
  logic        pl_we = 1'b0;
  logic [15:0] pl_a  = 16'd0;
  logic [7:0]  pl_d  = 8'd0;
  int          wr_cnt = 0;

  always @(posedge clk_in) begin
    ram_din_i <= ram[ram_a_o[15:0]];
    if (pl_we) begin
      ram[pl_a] <= pl_d;
    end else if (ram_wr_o) begin
      ram[ram_a_o[15:0]] <= ram_dout_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_in);
    pl_we = 1'b1;
    pl_a  = a;
    pl_d  = d;
  endtask

  int wr0;
  logic [31:0] exp_a [4];
  logic [7:0]  exp_d [4];

  initial begin
    rst_in      = 1'b1;
    if_req_i    = 1'b0;
    if_addr_i   = 32'd0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_len_i   = 2'b00;
    mem_addr_i  = 32'd0;
    mem_wdata_i = 32'd0;

    // Preload during reset.
    preload(16'h0100, 8'h13);
    preload(16'h0101, 8'h00);
    preload(16'h0102, 8'h00);
    preload(16'h0103, 8'h93);
    preload(16'h0010, 8'h34);
    preload(16'h0011, 8'h12);
    preload(16'h0200, 8'hEF);
    preload(16'h0201, 8'hBE);
    preload(16'h0202, 8'hAD);
    preload(16'h0203, 8'hDE);
    @(negedge clk_in);
    pl_we = 1'b0;
    #1;
    chk("rst_ram_a",     ram_a_o,         32'h0);
    chk("rst_ram_wr",    ram_wr_o,        32'h0);
    chk("rst_ram_dout",  ram_dout_o,      32'h0);
    chk("rst_if_data",   if_data_o,       32'h0);
    chk("rst_mem_rdata", mem_rdata_o,     32'h0);
    chk("rst_if_done",   if_done_o,       32'h0);
    chk("rst_mem_done",  mem_done_o,      32'h0);
    chk("rst_if_stall",  if_stall_req_o,  32'h0);
    chk("rst_mem_stall", mem_stall_req_o, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    // IF word read at 0x100: addresses in cycles 1-4, done in cycle 6.
    @(negedge clk_in);
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    #1;
    chk("if_rd_stall_c0", if_stall_req_o, 32'h1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      #1;
      if (c <= 4) chk("if_rd_addr", ram_a_o, 32'h100 + 32'(c - 1));
      chk("if_rd_wr",    ram_wr_o,       32'h0);
      chk("if_rd_done",  if_done_o,      32'(c == 6));
      chk("if_rd_stall", if_stall_req_o, 32'(c != 6));
    end
    chk("if_rd_data", if_data_o, 32'h93000013);
    @(negedge clk_in);
    if_req_i = 1'b0;
    #1;
    chk("if_rd_hold", if_data_o, 32'h93000013);
    chk("if_rd_done_clr", if_done_o, 32'h0);

    // MEM byte store at 0x2004.
    wr0 = wr_cnt;
    @(negedge clk_in);
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_len_i   = 2'b00;
    mem_addr_i  = 32'h2004;
    mem_wdata_i = 32'hAABBCCDD;
    #1;
    chk("sb_stall_c0", mem_stall_req_o, 32'h1);
    @(negedge clk_in);
    #1;
    chk("sb_wr_c1",   ram_wr_o,   32'h1);
    chk("sb_addr_c1", ram_a_o,    32'h2004);
    chk("sb_dout_c1", ram_dout_o, 32'hDD);
    chk("sb_done_c1", mem_done_o, 32'h0);
    @(negedge clk_in);
    #1;
    chk("sb_wr_c2",    ram_wr_o,        32'h0);
    chk("sb_done_c2",  mem_done_o,      32'h1);
    chk("sb_stall_c2", mem_stall_req_o, 32'h0);
    @(negedge clk_in);
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    #1;
    chk("sb_done_c3", mem_done_o, 32'h0);
    chk("sb_wr_c3",   ram_wr_o,   32'h0);
    chk("sb_count",   32'(wr_cnt - wr0), 32'd1);
    chk("sb_ram",     ram[16'h2004], 32'hDD);

    // MEM half load from 0x10: done in cycle 4.
    @(negedge clk_in);
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_len_i  = 2'b01;
    mem_addr_i = 32'h10;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk_in);
      #1;
      if (c <= 2) chk("lh_addr", ram_a_o, 32'h10 + 32'(c - 1));
      chk("lh_wr",   ram_wr_o,   32'h0);
      chk("lh_done", mem_done_o, 32'(c == 4));
    end
    chk("lh_data", mem_rdata_o, 32'h00001234);
    @(negedge clk_in);
    mem_req_i = 1'b0;

    // Simultaneous requests: MEM byte load 0x11 first, then IF 0x200.
    @(negedge clk_in);
    @(negedge clk_in);
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_len_i  = 2'b00;
    mem_addr_i = 32'h11;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h200;
    #1;
    chk("arb_if_stall_c0", if_stall_req_o, 32'h1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk_in);
      if (c == 4) mem_req_i = 1'b0;
      #1;
      chk("arb_if_stall", if_stall_req_o, 32'(c != 10));
      chk("arb_mem_done", mem_done_o,     32'(c == 3));
      chk("arb_if_done",  if_done_o,      32'(c == 10));
      if (c == 1) chk("arb_mem_addr",   ram_a_o, 32'h11);
      if (c == 5) chk("arb_if_addr0",   ram_a_o, 32'h200);
      if (c == 8) chk("arb_if_addr3",   ram_a_o, 32'h203);
      if (c == 3) chk("arb_mem_rdata",  mem_rdata_o, 32'h00000012);
    end
    chk("arb_if_data", if_data_o, 32'hDEADBEEF);
    @(negedge clk_in);
    if_req_i = 1'b0;

    // Word store wrapping past the top of the address space.
    exp_a[0] = 32'hFFFFFFFE; exp_d[0] = 8'h11;
    exp_a[1] = 32'hFFFFFFFF; exp_d[1] = 8'h22;
    exp_a[2] = 32'h00000000; exp_d[2] = 8'h33;
    exp_a[3] = 32'h00000001; exp_d[3] = 8'h44;
    wr0 = wr_cnt;
    @(negedge clk_in);
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_len_i   = 2'b10;
    mem_addr_i  = 32'hFFFFFFFE;
    mem_wdata_i = 32'h44332211;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      #1;
      chk("sw_wr",   ram_wr_o,   32'(c <= 4));
      chk("sw_done", mem_done_o, 32'(c == 5));
      if (c <= 4) begin
        chk("sw_addr", ram_a_o,    exp_a[c-1]);
        chk("sw_dout", ram_dout_o, 32'(exp_d[c-1]));
      end
    end
    @(negedge clk_in);
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    #1;
    chk("sw_count", 32'(wr_cnt - wr0), 32'd4);
    chk("sw_ram_fffe", ram[16'hFFFE], 32'h11);
    chk("sw_ram_ffff", ram[16'hFFFF], 32'h22);
    chk("sw_ram_0000", ram[16'h0000], 32'h33);
    chk("sw_ram_0001", ram[16'h0001], 32'h44);

    // Reset during cycle 2 of a word store.
    wr0 = wr_cnt;
    @(negedge clk_in);
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_len_i   = 2'b10;
    mem_addr_i  = 32'h3000;
    mem_wdata_i = 32'h87654321;
    @(negedge clk_in);
    #1;
    chk("rs_wr_c1",   ram_wr_o,   32'h1);
    chk("rs_dout_c1", ram_dout_o, 32'h21);
    @(negedge clk_in);
    #1;
    chk("rs_wr_c2",   ram_wr_o, 32'h1);
    chk("rs_addr_c2", ram_a_o,  32'h3001);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in    = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i  = 1'b0;
    #1;
    chk("rs_wr_c3",     ram_wr_o,    32'h0);
    chk("rs_addr_c3",   ram_a_o,     32'h0);
    chk("rs_dout_c3",   ram_dout_o,  32'h0);
    chk("rs_rdata_c3",  mem_rdata_o, 32'h0);
    chk("rs_ifdata_c3", if_data_o,   32'h0);
    for (int c = 4; c <= 8; c++) begin
      @(negedge clk_in);
      #1;
      chk("rs_no_done", mem_done_o, 32'h0);
      chk("rs_no_wr",   ram_wr_o,   32'h0);
    end
    chk("rs_count", 32'(wr_cnt - wr0), 32'd2);

    // Fresh IF read after the abandoned store.
    @(negedge clk_in);
    if_req_i  = 1'b1;
    if_addr_i = 32'h200;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      #1;
      if (c == 1) chk("post_rs_addr", ram_a_o, 32'h200);
      chk("post_rs_done", if_done_o, 32'(c == 6));
    end
    chk("post_rs_data", if_data_o, 32'hDEADBEEF);
    @(negedge clk_in);
    if_req_i = 1'b0;
    @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
